// File: rtl/display_scan_controller.sv
// display_scan_controller: time-multiplexes BCD digits onto one seven-segment decoder with per-slot blanking
module display_scan_controller #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         err_in,
  input  logic                          lz_en,
  output logic [3:0]                    dec_value,
  output logic                          dec_error,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  r_state, w_state_nx;
  logic [CW-1:0]           r_cnt, w_cnt_nx;
  logic [IW-1:0]           r_idx, w_idx_nx;
  logic [4*NUM_DIGITS-1:0] r_pend_dig, r_act_dig, w_src_dig;
  logic [NUM_DIGITS-1:0]   r_pend_err, r_act_err, w_src_err;
  logic                    r_pend_lz, r_act_lz, w_src_lz;
  logic [3:0]              r_dec_value;
  logic                    r_dec_error;
  logic                    w_last, w_slot_end, w_enter_blank, w_boundary;
  logic [NUM_DIGITS-1:0]   w_sup;
  logic                    w_acc;
  logic [3:0]              w_sel_dig;
  logic                    w_sel_err, w_sel_sup;

  assign w_last        = r_idx == IW'(NUM_DIGITS - 1);
  assign w_slot_end    = (r_state == SHOW) && (r_cnt == CW'(CLK_DIV - 1));
  assign w_enter_blank = (w_state_nx == BLANK) && (r_state != BLANK);
  assign w_boundary    = w_enter_blank && (w_idx_nx == '0);

  // A frame boundary hands the next word to the active set; a coincident load bypasses pending
  assign w_src_dig = w_boundary ? (load ? digits_in : r_pend_dig) : r_act_dig;
  assign w_src_err = w_boundary ? (load ? err_in : r_pend_err) : r_act_err;
  assign w_src_lz  = w_boundary ? (load ? lz_en : r_pend_lz) : r_act_lz;

  // State register: scan position within the slot and frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
    end
  end

  // Next-state: blank then show within each slot, advancing the digit at slot end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 1'b1;
    w_idx_nx   = r_idx;
    if (!enable) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
      w_idx_nx   = '0;
    end else if (r_state == IDLE) begin
      w_state_nx = BLANK;
      w_cnt_nx   = '0;
      w_idx_nx   = '0;
    end else if (r_state == BLANK && r_cnt == CW'(BLANK_CYC - 1)) begin
      w_state_nx = SHOW;
    end else if (w_slot_end) begin
      w_state_nx = BLANK;
      w_cnt_nx   = '0;
      w_idx_nx   = w_last ? '0 : r_idx + 1'b1;
    end
  end

  // Leading-zero suppression: a digit blanks only if it and everything above are plain zeros
  always_comb begin
    w_acc = 1'b1;
    w_sup = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_acc    = w_acc & (w_src_dig[4*k +: 4] == 4'd0) & ~w_src_err[k];
      w_sup[k] = w_acc & w_src_lz & (k != 0);
    end
    w_sel_dig = w_src_dig[4*w_idx_nx +: 4];
    w_sel_err = w_src_err[w_idx_nx];
    w_sel_sup = w_sup[w_idx_nx];
  end

  // Pending word captures every load; active word only changes on a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_dig <= '0;
      r_pend_err <= '0;
      r_pend_lz  <= 1'b0;
      r_act_dig  <= '0;
      r_act_err  <= '0;
      r_act_lz   <= 1'b0;
    end else begin
      if (load) begin
        r_pend_dig <= digits_in;
        r_pend_err <= err_in;
        r_pend_lz  <= lz_en;
      end
      if (w_boundary) begin
        r_act_dig <= w_src_dig;
        r_act_err <= w_src_err;
        r_act_lz  <= w_src_lz;
      end
    end
  end

  // Decoder inputs settle during blanking so the new digit is stable before it lights
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_value <= 4'd0;
      r_dec_error <= 1'b0;
    end else if (w_enter_blank) begin
      r_dec_value <= w_sel_err ? 4'd0 : (w_sel_sup ? 4'hF : w_sel_dig);
      r_dec_error <= w_sel_err;
    end
  end

  // Outputs: select lines lit only in SHOW, frame pulse on the last digit's final cycle
  always_comb begin
    dig_sel    = (r_state == SHOW) ? OFF ^ (NUM_DIGITS'(1) << r_idx) : OFF;
    frame_done = enable && w_slot_end && w_last;
    scan_idx   = r_idx;
    dec_value  = r_dec_value;
    dec_error  = r_dec_error;
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed vector and sequence checks of the digit scan controller
module tb_display_scan_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  err_in = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  dec_value;
  logic        dec_error;
  logic [3:0]  dig_sel;
  logic [1:0]  scan_idx;
  logic        frame_done;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  err;
    logic        lz;
    logic [15:0] val;
    logic [3:0]  er;
  } vec_t;

  vec_t vecs [9];

  display_scan_controller #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
    .err_in(err_in), .lz_en(lz_en), .dec_value(dec_value), .dec_error(dec_error),
    .dig_sel(dig_sel), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input vec_t v);
    int s;
    logic [3:0] e_sel;
    for (int c = 0; c < 32; c++) begin
      s = c / 8;
      e_sel = (c % 8 < 2) ? 4'hF : 4'hF ^ (4'b0001 << s);
      chk("dig_sel", 32'(dig_sel), 32'(e_sel));
      chk("scan_idx", 32'(scan_idx), 32'(s));
      chk("frame_done", 32'(frame_done), 32'(c == 31));
      chk("dec_value", 32'(dec_value), 32'(v.val[4*s +: 4]));
      chk("dec_error", 32'(dec_error), 32'(v.er[s]));
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b0000};
    vecs[1] = '{16'h0052, 4'b0000, 1'b1, 16'hFF52, 4'b0000};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'hFFF0, 4'b0000};
    vecs[3] = '{16'h0007, 4'b0100, 1'b1, 16'hF007, 4'b0100};
    vecs[4] = '{16'h0052, 4'b0000, 1'b0, 16'h0052, 4'b0000};
    vecs[5] = '{16'hABCD, 4'b0000, 1'b1, 16'hABCD, 4'b0000};
    vecs[6] = '{16'h0305, 4'b0000, 1'b1, 16'hF305, 4'b0000};
    vecs[7] = '{16'h9999, 4'b1111, 1'b1, 16'h0000, 4'b1111};
    vecs[8] = '{16'h1000, 4'b0000, 1'b1, 16'h1000, 4'b0000};

    #12;
    chk("rst_dig_sel", 32'(dig_sel), 32'hF);
    chk("rst_scan_idx", 32'(scan_idx), 0);
    chk("rst_dec_value", 32'(dec_value), 0);
    chk("rst_dec_error", 32'(dec_error), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      enable = 1'b0;
      tick();
      digits_in = vecs[i].dig;
      err_in = vecs[i].err;
      lz_en = vecs[i].lz;
      load = 1'b1;
      tick();
      load = 1'b0;
      enable = 1'b1;
      tick();
      check_frame(vecs[i]);
      check_frame(vecs[i]);
    end

    enable = 1'b0;
    tick();
    digits_in = 16'h1234; err_in = 4'b0; lz_en = 1'b0; load = 1'b1;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    repeat (10) tick();
    chk("mid_idx", 32'(scan_idx), 1);
    digits_in = 16'hAAAA; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    chk("mid_old_d2", 32'(dec_value), 2);
    repeat (8) tick();
    chk("mid_old_d3", 32'(dec_value), 1);
    repeat (8) tick();
    chk("mid_new_idx", 32'(scan_idx), 0);
    chk("mid_new_d0", 32'(dec_value), 32'hA);
    repeat (31) tick();
    chk("bnd_frame_done", 32'(frame_done), 1);
    digits_in = 16'h5678; load = 1'b1;
    tick();
    load = 1'b0;
    chk("bnd_d0", 32'(dec_value), 8);
    chk("bnd_blank", 32'(dig_sel), 32'hF);
    repeat (10) tick();
    chk("bnd_d1", 32'(dec_value), 7);
    chk("bnd_sel1", 32'(dig_sel), 32'hD);

    digits_in = 16'h0042; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (7) tick();
    chk("en_sel2", 32'(dig_sel), 32'hB);
    chk("en_idx2", 32'(scan_idx), 2);
    enable = 1'b0;
    tick();
    chk("dis_sel", 32'(dig_sel), 32'hF);
    chk("dis_idx", 32'(scan_idx), 0);
    repeat (3) tick();
    chk("dis_hold_sel", 32'(dig_sel), 32'hF);
    enable = 1'b1;
    tick();
    chk("reen_idx", 32'(scan_idx), 0);
    chk("reen_d0", 32'(dec_value), 2);
    repeat (10) tick();
    chk("reen_d1", 32'(dec_value), 4);
    chk("reen_sel1", 32'(dig_sel), 32'hD);

    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_dig_sel", 32'(dig_sel), 32'hF);
    chk("arst_scan_idx", 32'(scan_idx), 0);
    chk("arst_dec_value", 32'(dec_value), 0);
    chk("arst_dec_error", 32'(dec_error), 0);
    chk("arst_frame_done", 32'(frame_done), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_sel", 32'(dig_sel), 32'hF);
    chk("idle_idx", 32'(scan_idx), 0);
    enable = 1'b1;
    tick();
    repeat (2) tick();
    chk("post_rst_sel", 32'(dig_sel), 32'hE);
    chk("post_rst_val", 32'(dec_value), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
